// File: rtl/dispatch_route_lookup.sv
// Route-table responder: linear scan of {valid, key, mask} entries for a lookup key.
// Optional DISPATCH_ROUTE_DEFAULT_EN adds default_mask and answers misses with it.
module dispatch_route_lookup #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic             rd_yuv_start,
  input  logic [31:0]      rd_yuv_addr,
  output logic             rd_yuv_data_vld,
  output logic [7:0]       rd_yuv_data,
  input  logic             cfg_wr_en,
  input  logic [IDX_W-1:0] cfg_wr_idx,
  input  logic             cfg_wr_valid,
  input  logic [31:0]      cfg_wr_key,
  input  logic [7:0]       cfg_wr_mask,
`ifdef DISPATCH_ROUTE_DEFAULT_EN
  input  logic [7:0]       default_mask,
`endif
  output logic             lookup_busy,
  output logic             lookup_drop,
  output logic [15:0]      hit_cnt,
  output logic [15:0]      miss_cnt
);

  typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

  localparam logic [IDX_W:0] LastIdx  = (IDX_W+1)'(DEPTH - 1);
  localparam logic [IDX_W:0] DepthIdx = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] IdxOne   = (IDX_W+1)'(1);

`ifdef DISPATCH_ROUTE_DEFAULT_EN
  localparam logic DefaultEn = 1'b1;
  logic [7:0] dflt_mask;
  assign dflt_mask = default_mask;
`else
  localparam logic DefaultEn = 1'b0;
  logic [7:0] dflt_mask;
  assign dflt_mask = 8'h00;
`endif

  state_e           state_q, state_d;
  logic [IDX_W:0]   idx_q, idx_d;
  logic [31:0]      key_q, key_d;
  logic [7:0]       mask_q, mask_d;
  logic             hit_q, hit_d;
  logic [15:0]      hit_cnt_q, miss_cnt_q;
  logic             hit_inc, miss_inc;

  logic [DEPTH-1:0] ent_valid_q;
  logic [31:0]      ent_key_q  [DEPTH];
  logic [7:0]       ent_mask_q [DEPTH];

  logic [IDX_W-1:0] cur_idx;
  logic             cur_match;
  logic             wr_ok;

  assign cur_idx   = idx_q[IDX_W-1:0];
  assign cur_match = (idx_q < DepthIdx) && ent_valid_q[cur_idx] && (ent_key_q[cur_idx] == key_q);
  assign wr_ok     = cfg_wr_en && ({1'b0, cfg_wr_idx} < DepthIdx);

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    key_d           = key_q;
    mask_d          = mask_q;
    hit_d           = hit_q;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    rd_yuv_data_vld = 1'b0;
    rd_yuv_data     = 8'h00;
    lookup_drop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_yuv_start) begin
          key_d   = rd_yuv_addr;
          idx_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        lookup_drop = rd_yuv_start;
        if (cur_match) begin
          mask_d  = ent_mask_q[cur_idx];
          hit_d   = 1'b1;
          state_d = StResp;
        end else if (DefaultEn && (idx_q == DepthIdx)) begin
          // One extra slot past the table acts as the default entry.
          mask_d  = dflt_mask;
          hit_d   = 1'b0;
          state_d = StResp;
        end else if (idx_q == LastIdx) begin
          miss_inc = 1'b1;
          if (DefaultEn) idx_d = idx_q + IdxOne;
          else           state_d = StIdle;
        end else begin
          idx_d = idx_q + IdxOne;
        end
      end
      StResp: begin
        rd_yuv_data_vld = 1'b1;
        rd_yuv_data     = mask_q;
        lookup_drop     = rd_yuv_start;
        hit_inc         = hit_q;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign lookup_busy = (state_q != StIdle);
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      key_q      <= '0;
      mask_q     <= '0;
      hit_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      mask_q  <= mask_d;
      hit_q   <= hit_d;
      if (hit_inc && (hit_cnt_q != 16'hFFFF))   hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (miss_inc && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      ent_valid_q <= '0;
    end else if (wr_ok) begin
      ent_valid_q[cfg_wr_idx] <= cfg_wr_valid;
    end
  end

  // Key and mask storage needs no reset; valid gates their use.
  always_ff @(posedge clk_sys) begin
    if (wr_ok) begin
      ent_key_q[cfg_wr_idx]  <= cfg_wr_key;
      ent_mask_q[cfg_wr_idx] <= cfg_wr_mask;
    end
  end

endmodule
